// File: rtl/scarv_cop_issue_pkg.sv
// Shared definitions for the SCARV coprocessor issue stage: buffer depth, FSM encodings, payload types.
// Define SCARV_COP_ISSUE_BUF_EN to get a two-entry issue buffer; otherwise a single holding register.
package scarv_cop_issue_pkg;

`ifdef SCARV_COP_ISSUE_BUF_EN
    localparam int SCARV_COP_ISSUE_DEPTH = 2;
`else
    localparam int SCARV_COP_ISSUE_DEPTH = 1;
`endif

    localparam int SCARV_COP_ISSUE_CNT_W = $clog2(SCARV_COP_ISSUE_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [31:0] enc;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } issue_entry_t;

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        exc;
    } issue_rsp_t;

    // A faulting instruction must never write the register file.
    function automatic issue_rsp_t mask_rsp(input logic wen, input logic [4:0] rd,
                                            input logic [31:0] wdata, input logic exc);
        issue_rsp_t r;
        r.wen   = wen & ~exc;
        r.rd    = rd;
        r.wdata = wdata;
        r.exc   = exc;
        return r;
    endfunction

endpackage

// File: rtl/scarv_cop_issue_fifo.sv
// In-order instruction buffer with registered occupancy; depth 1 degenerates to a holding register.
module scarv_cop_issue_fifo #(
    parameter int DEPTH = 1,
    parameter int W     = 96
) (
    input  logic                           g_clk,
    input  logic                           g_resetn,
    input  logic                           push_i,
    input  logic [W-1:0]                   din_i,
    input  logic                           pop_i,
    output logic [W-1:0]                   dout_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    if (DEPTH == 1) begin : g_single
        logic [W-1:0] data_q;

        // Single holding register.
        always_ff @(posedge g_clk or negedge g_resetn) begin
            if (!g_resetn) begin
                data_q <= '0;
            end else if (push_ok_s) begin
                data_q <= din_i;
            end
        end

        assign dout_o = data_q;
    end else begin : g_ring
        localparam int PTR_W = $clog2(DEPTH);

        logic [W-1:0]     mem_q [DEPTH];
        logic [PTR_W-1:0] wr_ptr_q;
        logic [PTR_W-1:0] rd_ptr_q;

        function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
            if (p == PTR_W'(DEPTH - 1)) begin
                return '0;
            end
            return p + PTR_W'(1);
        endfunction

        // Ring storage and wrapping pointers.
        always_ff @(posedge g_clk or negedge g_resetn) begin
            if (!g_resetn) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok_s) begin
                    mem_q[wr_ptr_q] <= din_i;
                    wr_ptr_q        <= ptr_inc(wr_ptr_q);
                end
                if (pop_ok_s) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
            end
        end

        assign dout_o = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/scarv_cop_issue.sv
// Coprocessor issue stage: buffers host instructions, issues one at a time, holds the response.
// Buffer depth is 2 when SCARV_COP_ISSUE_BUF_EN is defined, otherwise 1.
module scarv_cop_issue
    import scarv_cop_issue_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cpu_insn_req,
    output logic        cpu_insn_ack,
    input  logic [31:0] cpu_insn_enc,
    input  logic [31:0] cpu_rs1,
    input  logic [31:0] cpu_rs2,
    output logic        cop_insn_valid,
    input  logic        cop_insn_ready,
    output logic [31:0] cop_insn_enc,
    output logic [31:0] cop_rs1,
    output logic [31:0] cop_rs2,
    input  logic        cop_rsp_valid,
    output logic        cop_rsp_ready,
    input  logic        cop_rsp_wen,
    input  logic [4:0]  cop_rsp_rd,
    input  logic [31:0] cop_rsp_wdata,
    input  logic        cop_rsp_exc,
    output logic        cpu_rsp_valid,
    input  logic        cpu_rsp_ready,
    output logic        cpu_rsp_wen,
    output logic [4:0]  cpu_rsp_rd,
    output logic [31:0] cpu_rsp_wdata,
    output logic        cpu_rsp_exc,
    output logic        busy
);
    issue_state_t                     state_q;
    issue_state_t                     state_d;
    issue_entry_t                     fifo_din_s;
    issue_entry_t                     fifo_dout_s;
    issue_rsp_t                       rsp_q;
    logic                             fifo_full_s;
    logic                             fifo_empty_s;
    logic [SCARV_COP_ISSUE_CNT_W-1:0] fifo_count_s;
    logic                             push_s;
    logic                             pop_s;
    logic                             capture_s;

    assign fifo_din_s = '{enc: cpu_insn_enc, rs1: cpu_rs1, rs2: cpu_rs2};

    // Ack looks only at registered occupancy, and is held low while in reset.
    assign cpu_insn_ack   = g_resetn & ~fifo_full_s;
    assign push_s         = cpu_insn_req & cpu_insn_ack;
    assign cop_insn_valid = (state_q == ST_IDLE) & ~fifo_empty_s;
    assign pop_s          = cop_insn_valid & cop_insn_ready;
    assign cop_rsp_ready  = (state_q == ST_EXEC);
    assign capture_s      = cop_rsp_ready & cop_rsp_valid;
    assign cpu_rsp_valid  = (state_q == ST_RESP);
    assign busy           = (fifo_count_s != '0) | (state_q != ST_IDLE);

    assign cop_insn_enc  = fifo_dout_s.enc;
    assign cop_rs1       = fifo_dout_s.rs1;
    assign cop_rs2       = fifo_dout_s.rs2;
    assign cpu_rsp_wen   = rsp_q.wen;
    assign cpu_rsp_rd    = rsp_q.rd;
    assign cpu_rsp_wdata = rsp_q.wdata;
    assign cpu_rsp_exc   = rsp_q.exc;

    scarv_cop_issue_fifo #(
        .DEPTH (SCARV_COP_ISSUE_DEPTH),
        .W     ($bits(issue_entry_t))
    ) u_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push_i   (push_s),
        .din_i    (fifo_din_s),
        .pop_i    (pop_s),
        .dout_o   (fifo_dout_s),
        .full_o   (fifo_full_s),
        .empty_o  (fifo_empty_s),
        .count_o  (fifo_count_s)
    );

    // Issue FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cop_rsp_valid) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (cpu_rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue FSM state register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response holding register, loaded once when execute completes.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rsp_q <= '0;
        end else if (capture_s) begin
            rsp_q <= mask_rsp(cop_rsp_wen, cop_rsp_rd, cop_rsp_wdata, cop_rsp_exc);
        end
    end

endmodule

// File: tb/tb_scarv_cop_issue.sv
// Self-checking bench for scarv_cop_issue: directed scenarios then random traffic against a queue model.
module tb_scarv_cop_issue;
`ifdef SCARV_COP_ISSUE_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        g_clk, g_resetn;
    logic        cpu_insn_req, cpu_insn_ack;
    logic [31:0] cpu_insn_enc, cpu_rs1, cpu_rs2;
    logic        cop_insn_valid, cop_insn_ready;
    logic [31:0] cop_insn_enc, cop_rs1, cop_rs2;
    logic        cop_rsp_valid, cop_rsp_ready;
    logic        cop_rsp_wen, cop_rsp_exc;
    logic [4:0]  cop_rsp_rd;
    logic [31:0] cop_rsp_wdata;
    logic        cpu_rsp_valid, cpu_rsp_ready;
    logic        cpu_rsp_wen, cpu_rsp_exc;
    logic [4:0]  cpu_rsp_rd;
    logic [31:0] cpu_rsp_wdata;
    logic        busy;

    scarv_cop_issue dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1), .cpu_rs2(cpu_rs2),
        .cop_insn_valid(cop_insn_valid), .cop_insn_ready(cop_insn_ready),
        .cop_insn_enc(cop_insn_enc), .cop_rs1(cop_rs1), .cop_rs2(cop_rs2),
        .cop_rsp_valid(cop_rsp_valid), .cop_rsp_ready(cop_rsp_ready),
        .cop_rsp_wen(cop_rsp_wen), .cop_rsp_rd(cop_rsp_rd),
        .cop_rsp_wdata(cop_rsp_wdata), .cop_rsp_exc(cop_rsp_exc),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
        .cpu_rsp_wen(cpu_rsp_wen), .cpu_rsp_rd(cpu_rsp_rd),
        .cpu_rsp_wdata(cpu_rsp_wdata), .cpu_rsp_exc(cpu_rsp_exc),
        .busy(busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: instructions waiting on the host, instructions buffered,
    // whether one is executing, and whether a response is held (with its value).
    logic [95:0] host_q[$];
    logic [95:0] model_q[$];
    bit          exec_f;
    bit          held_f;
    logic [38:0] exp_rsp;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge g_clk);
        g_resetn = 1'b0;
        cpu_insn_req = 1'b0;
        #1;
        check("rst_ack", {95'd0, cpu_insn_ack}, 96'd0);
        check("rst_cop_valid", {95'd0, cop_insn_valid}, 96'd0);
        check("rst_cop_insn", {cop_insn_enc, cop_rs1, cop_rs2}, 96'd0);
        check("rst_cop_rsp_ready", {95'd0, cop_rsp_ready}, 96'd0);
        check("rst_cpu_rsp", {57'd0, cpu_rsp_valid, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_exc}, 96'd0);
        check("rst_busy", {95'd0, busy}, 96'd0);
        host_q.delete();
        model_q.delete();
        exec_f = 1'b0;
        held_f = 1'b0;
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
    endtask

    task automatic step(input bit ins_rdy, input bit rsp_v, input logic r_wen,
                        input logic [4:0] r_rd, input logic [31:0] r_wd, input logic r_exc,
                        input bit out_rdy);
        bit          exp_valid, req, push, pop, cap, rel;
        logic [95:0] hd;
        @(negedge g_clk);
        exp_valid = !exec_f && !held_f && (model_q.size() > 0);
        check("ack", {95'd0, cpu_insn_ack}, {95'd0, model_q.size() < DEPTH});
        check("cop_valid", {95'd0, cop_insn_valid}, {95'd0, exp_valid});
        if (exp_valid) check("cop_insn", {cop_insn_enc, cop_rs1, cop_rs2}, model_q[0]);
        check("cop_rsp_ready", {95'd0, cop_rsp_ready}, {95'd0, exec_f});
        check("cpu_rsp_valid", {95'd0, cpu_rsp_valid}, {95'd0, held_f});
        if (held_f) check("cpu_rsp", {57'd0, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_exc}, {57'd0, exp_rsp});
        check("busy", {95'd0, busy}, {95'd0, (model_q.size() > 0) || exec_f || held_f});

        req = host_q.size() > 0;
        cpu_insn_req = req;
        if (req) {cpu_insn_enc, cpu_rs1, cpu_rs2} = host_q[0];
        else     {cpu_insn_enc, cpu_rs1, cpu_rs2} = {$urandom, $urandom, $urandom};
        cop_insn_ready = ins_rdy;
        cop_rsp_valid  = rsp_v;
        cop_rsp_wen    = r_wen;
        cop_rsp_rd     = r_rd;
        cop_rsp_wdata  = r_wd;
        cop_rsp_exc    = r_exc;
        cpu_rsp_ready  = out_rdy;

        push = req && (model_q.size() < DEPTH);
        pop  = exp_valid && ins_rdy;
        cap  = exec_f && rsp_v;
        rel  = held_f && out_rdy;
        @(posedge g_clk);
        if (pop) begin hd = model_q.pop_front(); exec_f = 1'b1; end
        if (cap) begin exec_f = 1'b0; held_f = 1'b1; exp_rsp = {r_wen && !r_exc, r_rd, r_wd, r_exc}; end
        if (rel) held_f = 1'b0;
        if (push) begin hd = host_q.pop_front(); model_q.push_back(hd); end
    endtask

    initial begin
        g_resetn = 1'b0;
        cpu_insn_req = 1'b0; cpu_insn_enc = 32'd0; cpu_rs1 = 32'd0; cpu_rs2 = 32'd0;
        cop_insn_ready = 1'b0; cop_rsp_valid = 1'b0; cop_rsp_wen = 1'b0;
        cop_rsp_rd = 5'd0; cop_rsp_wdata = 32'd0; cop_rsp_exc = 1'b0; cpu_rsp_ready = 1'b0;
        do_reset();

        // Single operation.
        host_q.push_back({32'h0000_102B, 32'h0000_0010, 32'h0000_0000});
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        // Exception masks the write enable.
        host_q.push_back({32'h1234_5678, 32'h1, 32'h2});
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5'd7, 32'hCAFE_0001, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        // Spurious response while idle is ignored.
        step(1'b0, 1'b1, 1'b1, 5'd9, 32'h5555_AAAA, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 5'd9, 32'h5555_AAAA, 1'b0, 1'b1);

        // Response stall with a second instruction buffered behind it.
        host_q.push_back({32'hA000_0001, 32'h11, 32'h12});
        host_q.push_back({32'hA000_0002, 32'h21, 32'h22});
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 5'd3, 32'h0BAD_F00D, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 5'd1, 32'h1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 5'd4, 32'h4444_4444, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        // Backpressure: three back-to-back requests with execute stalled.
        host_q.push_back({32'hB000_0001, 32'h1, 32'h1});
        host_q.push_back({32'hB000_0002, 32'h2, 32'h2});
        host_q.push_back({32'hB000_0003, 32'h3, 32'h3});
        repeat (4) step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b1, 5'(k), 32'(k), 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // Reset mid-execute with one instruction buffered.
        host_q.push_back({32'hC000_0001, 32'h1, 32'h1});
        host_q.push_back({32'hC000_0002, 32'h2, 32'h2});
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        do_reset();
        repeat (3) step(1'b1, 1'b1, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 1'b1);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            if (host_q.size() < 2 && $urandom_range(0, 1) == 1)
                host_q.push_back({$urandom, $urandom, $urandom});
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom),
                 5'($urandom), $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scarv_cop_issue.md
SCARV_COP_ISSUE -- requirements
Module: scarv_cop_issue

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- g_clk  in  1  sole clock, rising edge.
- g_resetn  in  1  asynchronous, active-low reset.
- cpu_insn_req  in  1  host offers an instruction.
- cpu_insn_ack  out  1  instruction accepted this cycle (req && ack).
- cpu_insn_enc  in  32  encoded instruction.
- cpu_rs1, cpu_rs2  in  32  GPR operand values.
- cop_insn_valid  out  1  instruction presented to decode/execute.
- cop_insn_ready  in  1  decode/execute takes it.
- cop_insn_enc, cop_rs1, cop_rs2  out  32  presented instruction and operands.
- cop_rsp_valid  in  1  execute has completed.
- cop_rsp_ready  out  1  execute response accepted.
- cop_rsp_wen, cop_rsp_rd, cop_rsp_wdata, cop_rsp_exc  in  1/5/32/1  GPR write enable, rd, data, illegal-instruction flag.
- cpu_rsp_valid  out  1  response held for host.
- cpu_rsp_ready  in  1  host consumes the response.
- cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_exc  out  1/5/32/1  registered copies of the response.
- busy  out  1  buffer non-empty or state != IDLE.

Function
REQ-002 SHALL buffer accepted instructions in an in-order FIFO of depth DEPTH (2 or 1, see Configuration), each entry {enc, rs1, rs2}.
REQ-003 SHALL derive cpu_insn_ack from registered occupancy only: ack = (count < DEPTH); a same-cycle pop frees no slot.
REQ-004 SHALL make an accepted entry visible on cop_insn_* no earlier than the next cycle.
REQ-005 SHALL run FSM IDLE/EXEC/RESP: IDLE->EXEC on cop_insn_valid && cop_insn_ready (FIFO pop); EXEC->RESP on cop_rsp_valid; RESP->IDLE on cpu_rsp_ready.
REQ-006 SHALL drive cop_insn_valid = (state==IDLE) && (count!=0); at most one instruction outstanding in execute.
REQ-007 SHALL hold cop_insn_* stable while cop_insn_valid && !cop_insn_ready.
REQ-008 SHALL drive cop_rsp_ready = (state==EXEC); cop_rsp_valid in other states is ignored.
REQ-009 SHALL capture cop_rsp_* into the response register on EXEC->RESP; cpu_rsp_valid = (state==RESP), payload stable until cpu_rsp_ready.
REQ-010 SHALL force cpu_rsp_wen=0 when cop_rsp_exc=1 at capture.
REQ-011 SHALL on simultaneous push and pop keep count unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-012 SHALL leave count unchanged when cpu_insn_req=1 and count==DEPTH (no acceptance, no overwrite).

Reset
REQ-013 SHALL, while g_resetn=0, immediately force state=IDLE, count=0, pointers=0, and all outputs to 0 (cpu_insn_ack=0).
REQ-014 SHALL discard buffered instructions and any held response on reset mid-operation; no response is ever delivered for them.
REQ-015 SHALL assert cpu_insn_ack=1 in the first cycle after reset release.

Configuration
REQ-016 SHALL with SCARV_COP_ISSUE_BUF_EN defined use DEPTH=2 (back-to-back host issue while one instruction executes).
REQ-017 SHALL without SCARV_COP_ISSUE_BUF_EN use DEPTH=1 (single holding register); all other behaviour is identical.

Structure
REQ-018 SHALL place FSM state encodings and SCARV_COP_ISSUE_DEPTH in the shared scarv_cop_common.vh.
REQ-019 SHALL implement the FIFO as sub-module scarv_cop_issue_fifo (push/pop/full/empty/count, parameterised by depth).

Verification
REQ-020 Reset: g_resetn=0 mid-EXEC with count=1 -> after release busy=0, cpu_rsp_valid=0, cpu_insn_ack=1, no response emitted.
REQ-021 Single op: enc=0x0000_102B, rs1=0x10, cop_insn_ready=1, rsp {wen=1, rd=5, wdata=0xDEADBEEF} -> cpu_rsp returns exactly those values once.
REQ-022 Backpressure (BUF_EN): 3 back-to-back req with execute stalled -> first 2 acked, 3rd held with ack=0 until first pop; issue order 1,2,3.
REQ-023 Exception: rsp {exc=1, wen=1, rd=7} -> cpu_rsp_exc=1, cpu_rsp_wen=0.
REQ-024 Response stall: cpu_rsp_ready=0 for 5 cycles -> payload stable, cop_insn_valid=0 despite count=1, cop_rsp_ready=0.
REQ-025 Spurious rsp: cop_rsp_valid=1 in IDLE -> no state change, cpu_rsp_valid stays 0.
